// File: rtl/spectrum_magnitude_engine.sv
// spectrum_magnitude_engine: complex FFT beats -> tagged magnitude (4-stage, backpressured) with per-channel frame peak report; ports clk/rst, in_* beat stream + in_ready, mode, out_* result stream + out_ready, peak_* report, frame_err
module spectrum_magnitude_engine #(
  parameter int DATA_W = 16,
  parameter int FFT_LEN_LOG2 = 13,
  parameter int NUM_CH = 2,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_W-1:0]     in_data,
  input  logic [CH_W-1:0]         in_ch,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic [1:0]              mode,
  output logic [DATA_W-1:0]       out_mag,
  output logic [FFT_LEN_LOG2-1:0] out_bin,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       peak_mag,
  output logic [FFT_LEN_LOG2-1:0] peak_bin,
  output logic [CH_W-1:0]         peak_ch,
  output logic                    peak_valid,
  output logic                    frame_err
);
  localparam int NS = 2**CH_W;
  localparam logic [2*DATA_W:0] SQ_MAX = {2'b00, {(2*DATA_W-1){1'b1}}};
  typedef struct packed {
    logic                    v;
    logic [CH_W-1:0]         ch;
    logic [FFT_LEN_LOG2-1:0] bin;
    logic [1:0]              md;
    logic                    cls;
    logic                    err;
  } tag_t;
  tag_t t0, t1, t2, t3;
  logic [FFT_LEN_LOG2-1:0] bin_cnt [NS];
  logic [1:0]              md_lat [NS];
  logic [DATA_W-1:0]       pk_mag [NS];
  logic [FFT_LEN_LOG2-1:0] pk_bin [NS];
  logic [2*DATA_W-1:0] r0;
  logic [DATA_W-1:0] s1_re, s1_im, s2_mx, s2_mn, s3_mx, s3_term;
  logic [2*DATA_W:0] s3_sq;
  logic [CH_W-1:0] rep_ch;
  logic rep_pend, en, acc, ch_ok, last_bin, upd, load;
  logic [FFT_LEN_LOG2-1:0] cur;
  logic [1:0] m_eff, md_new;
  logic [DATA_W-1:0] a_re, a_im, term, mag;
  logic [DATA_W+1:0] t38;
  logic [2*DATA_W-1:0] p_mx, p_mn;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  always_comb begin
    acc = in_valid && en;
    ch_ok = int'(in_ch) < NUM_CH;
    cur = bin_cnt[in_ch];
    last_bin = &cur;
    m_eff = mode == 2'd3 ? 2'd0 : mode;
    md_new = cur == '0 ? m_eff : md_lat[in_ch];
    a_re = r0[DATA_W-1] ? ~r0[DATA_W-1:0] + 1'b1 : r0[DATA_W-1:0];
    a_im = r0[2*DATA_W-1] ? ~r0[2*DATA_W-1:DATA_W] + 1'b1 : r0[2*DATA_W-1:DATA_W];
    t38 = {2'b00, s2_mn} + {1'b0, s2_mn, 1'b0};
    term = t2.md == 2'd1 ? DATA_W'(t38 >> 3) : s2_mn >> 1;
    p_mx = {{DATA_W{1'b0}}, s2_mx} * {{DATA_W{1'b0}}, s2_mx};
    p_mn = {{DATA_W{1'b0}}, s2_mn} * {{DATA_W{1'b0}}, s2_mn};
    mag = t3.md == 2'd2 ? (s3_sq > SQ_MAX ? '1 : DATA_W'(s3_sq >> (DATA_W-1))) : s3_mx + s3_term;
    upd = t3.bin == '0 || mag > pk_mag[t3.ch];
    load = en && t3.v;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t0 <= '0;
      t1 <= '0;
      t2 <= '0;
      t3 <= '0;
      r0 <= '0;
      s1_re <= '0;
      s1_im <= '0;
      s2_mx <= '0;
      s2_mn <= '0;
      s3_mx <= '0;
      s3_term <= '0;
      s3_sq <= '0;
      out_mag <= '0;
      out_bin <= '0;
      out_ch <= '0;
      out_valid <= 1'b0;
      peak_mag <= '0;
      peak_bin <= '0;
      peak_ch <= '0;
      peak_valid <= 1'b0;
      frame_err <= 1'b0;
      rep_pend <= 1'b0;
      rep_ch <= '0;
      for (int i = 0; i < NS; i++) begin
        bin_cnt[i] <= '0;
        md_lat[i] <= '0;
        pk_mag[i] <= '0;
        pk_bin[i] <= '0;
      end
    end else begin
      if (acc && ch_ok) begin
        bin_cnt[in_ch] <= last_bin || in_last ? '0 : cur + 1'b1;
        md_lat[in_ch] <= md_new;
      end
      if (en) begin
        t0 <= '{v: acc && ch_ok, ch: in_ch, bin: cur, md: md_new, cls: last_bin || in_last, err: in_last && !last_bin};
        r0 <= in_data;
        t1 <= t0;
        s1_re <= a_re;
        s1_im <= a_im;
        t2 <= t1;
        s2_mx <= s1_re >= s1_im ? s1_re : s1_im;
        s2_mn <= s1_re >= s1_im ? s1_im : s1_re;
        t3 <= t2;
        s3_mx <= s2_mx;
        s3_term <= term;
        s3_sq <= {1'b0, p_mx} + {1'b0, p_mn};
        out_valid <= t3.v;
      end
      if (load) begin
        out_mag <= mag;
        out_bin <= t3.bin;
        out_ch <= t3.ch;
        pk_mag[t3.ch] <= upd ? mag : pk_mag[t3.ch];
        pk_bin[t3.ch] <= upd ? t3.bin : pk_bin[t3.ch];
      end
      frame_err <= load && t3.err;
      rep_pend <= load && t3.cls;
      rep_ch <= t3.ch;
      peak_valid <= rep_pend;
      if (rep_pend) begin
        peak_mag <= pk_mag[rep_ch];
        peak_bin <= pk_bin[rep_ch];
        peak_ch <= rep_ch;
      end
    end
  end
endmodule

// File: tb/tb_spectrum_magnitude_engine.sv
// tb_spectrum_magnitude_engine: scoreboard bench for spectrum_magnitude_engine (DATA_W=16, FFT_LEN_LOG2=4, NUM_CH=2)
`timescale 1ns/1ps
module tb_spectrum_magnitude_engine;
  localparam int DW = 16, LG = 4, NC = 2, FL = 16;
  logic clk = 0, rst = 1;
  logic [2*DW-1:0] in_data = '0;
  logic in_ch = 0, in_valid = 0, in_last = 0, in_ready, out_ready = 1;
  logic [1:0] mode = 0;
  logic [DW-1:0] out_mag, peak_mag;
  logic [LG-1:0] out_bin, peak_bin;
  logic out_ch, peak_ch, out_valid, peak_valid, frame_err;
  int errors = 0, checks = 0, cyc = 0, fe_cnt = 0, pk_cnt = 0;
  bit rnd = 0, held = 0;
  typedef struct { logic [DW-1:0] mag; logic [LG-1:0] bin; logic ch; logic err; int acc; bit lat; } exp_t;
  typedef struct { logic [DW-1:0] mag; logic [LG-1:0] bin; logic ch; int acc; bit lat; } pk_t;
  exp_t oq[$];
  pk_t pq[$];
  exp_t e;
  pk_t p;
  int mbin[NC], mlat[NC], pkb[NC];
  logic [DW-1:0] pkm[NC], lpk_mag[NC];
  logic [LG-1:0] lpk_bin[NC];
  logic [DW+LG:0] prev;
  logic exp_fe;

  spectrum_magnitude_engine #(.DATA_W(DW), .FFT_LEN_LOG2(LG), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_ch(in_ch), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .mode(mode), .out_mag(out_mag), .out_bin(out_bin), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .peak_mag(peak_mag), .peak_bin(peak_bin),
    .peak_ch(peak_ch), .peak_valid(peak_valid), .frame_err(frame_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input bit ok, input longint obs, input longint want);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, want);
    end
  endtask

  function automatic logic [DW-1:0] model_mag(input int re, input int im, input int md);
    longint a, b, mx, mn, s;
    a = re < 0 ? -re : re;
    b = im < 0 ? -im : im;
    mx = a >= b ? a : b;
    mn = a >= b ? b : a;
    if (md == 2) begin
      s = (a * a + b * b) >> 15;
      if (s > 65535) s = 65535;
    end else if (md == 1) s = mx + (3 * mn) / 8;
    else s = mx + mn / 2;
    return s[DW-1:0];
  endfunction

  always @(negedge clk) begin
    if (rst) held = 0;
    else begin
      if (held) chk("stable", {out_valid, out_ch, out_bin, out_mag} === {1'b1, prev}, {out_valid, out_ch, out_bin, out_mag}, {1'b1, prev});
      exp_fe = (out_valid && !held && oq.size() > 0) ? oq[0].err : 1'b0;
      chk("frame_err", frame_err === exp_fe, frame_err, exp_fe);
      if (frame_err) fe_cnt++;
      if (out_valid) begin
        chk("out_expected", oq.size() > 0, oq.size(), 1);
        if (oq.size() > 0) begin
          if (!held && oq[0].lat) chk("latency", cyc - oq[0].acc == 4, cyc - oq[0].acc, 4);
          if (out_ready) begin
            e = oq.pop_front();
            chk("out", {out_ch, out_bin, out_mag} === {e.ch, e.bin, e.mag}, {out_ch, out_bin, out_mag}, {e.ch, e.bin, e.mag});
          end
        end
      end
      if (peak_valid) begin
        pk_cnt++;
        lpk_mag[peak_ch] = peak_mag;
        lpk_bin[peak_ch] = peak_bin;
        chk("peak_expected", pq.size() > 0, pq.size(), 1);
        if (pq.size() > 0) begin
          p = pq.pop_front();
          chk("peak", {peak_ch, peak_bin, peak_mag} === {p.ch, p.bin, p.mag}, {peak_ch, peak_bin, peak_mag}, {p.ch, p.bin, p.mag});
          if (p.lat) chk("peak_latency", cyc - p.acc == 5, cyc - p.acc, 5);
        end
      end
      held = out_valid && !out_ready;
      prev = {out_ch, out_bin, out_mag};
    end
  end

  task automatic send(input int ch, input int re, input int im, input bit last);
    int n = 0, b;
    bit ok = 0, cls;
    logic [DW-1:0] m;
    in_data = {im[DW-1:0], re[DW-1:0]};
    in_ch = ch[0];
    in_last = last;
    in_valid = 1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 0;
    in_last = 0;
    if (!ok) chk("accept", ok === 1'b1, ok, 1);
    else begin
      b = mbin[ch];
      if (b == 0) mlat[ch] = mode == 2'd3 ? 0 : int'(mode);
      m = model_mag(re, im, mlat[ch]);
      cls = b == FL - 1 || last;
      if (b == 0 || m > pkm[ch]) begin
        pkm[ch] = m;
        pkb[ch] = b;
      end
      oq.push_back('{m, LG'(b), ch[0], last && b != FL - 1, cyc, !rnd});
      if (cls) pq.push_back('{pkm[ch], LG'(pkb[ch]), ch[0], cyc, !rnd});
      mbin[ch] = cls ? 0 : b + 1;
    end
  endtask

  task automatic frame(input int ch, input int pb, input int re, input int im);
    for (int b = 0; b < FL; b++) send(ch, b == pb ? re : 0, b == pb ? im : 0, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((oq.size() > 0 || pq.size() > 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain", oq.size() + pq.size() == 0, oq.size() + pq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    for (int c = 0; c < NC; c++) begin
      mbin[c] = 0; mlat[c] = 0; pkb[c] = 0; pkm[c] = 0; lpk_mag[c] = 0; lpk_bin[c] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid === 1'b0, out_valid, 0);
    chk("rst_out_mag", out_mag === 16'd0, out_mag, 0);
    chk("rst_peak_valid", peak_valid === 1'b0, peak_valid, 0);
    chk("rst_peak_mag", peak_mag === 16'd0, peak_mag, 0);
    chk("rst_frame_err", frame_err === 1'b0, frame_err, 0);
    chk("rst_in_ready", in_ready === 1'b1, in_ready, 1);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    mode = 0; frame(0, 5, 100, -40); drain();
    chk("m0_peak_mag", peak_mag === 16'd120, peak_mag, 120);
    chk("m0_peak_bin", peak_bin === 4'd5, peak_bin, 5);
    mode = 1; frame(0, 5, 100, -40); drain();
    chk("m1_peak_mag", peak_mag === 16'd115, peak_mag, 115);
    chk("m1_peak_bin", peak_bin === 4'd5, peak_bin, 5);
    mode = 2; frame(0, 5, 100, -40); drain();
    chk("m2_peak_mag", peak_mag === 16'd0, peak_mag, 0);
    chk("m2_peak_bin", peak_bin === 4'd0, peak_bin, 0);
    mode = 2; frame(0, 3, -32768, -32768); drain();
    chk("m2_sat_mag", peak_mag === 16'd65535, peak_mag, 65535);
    chk("m2_sat_bin", peak_bin === 4'd3, peak_bin, 3);
    mode = 0; frame(0, 3, -32768, -32768); drain();
    chk("m0_full_mag", peak_mag === 16'd49152, peak_mag, 49152);
    mode = 3; frame(0, 5, 100, -40); drain();
    chk("m3_peak_mag", peak_mag === 16'd120, peak_mag, 120);
    rnd = 1;
    for (int f = 0; f < 3; f++) begin
      mode = 2'($urandom_range(0, 3));
      for (int b = 0; b < FL; b++)
        send(0, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 0);
    end
    rnd = 0;
    drain();
    mode = 0;
    pc = pk_cnt;
    for (int b = 0; b < FL; b++) begin
      send(0, b == 3 ? 3000 : b, 7, 0);
      send(1, b == 12 ? -2500 : 2 * b, 1, 0);
    end
    drain();
    chk("two_ch_reports", pk_cnt - pc == 2, pk_cnt - pc, 2);
    chk("ch0_peak_bin", lpk_bin[0] === 4'd3, lpk_bin[0], 3);
    chk("ch1_peak_bin", lpk_bin[1] === 4'd12, lpk_bin[1], 12);
    for (int b = 0; b < FL; b++) send(0, (b == 2 || b == 9) ? 500 : 10, 0, 0);
    drain();
    chk("tie_peak_bin", lpk_bin[0] === 4'd2, lpk_bin[0], 2);
    chk("tie_peak_mag", lpk_mag[0] === 16'd500, lpk_mag[0], 500);
    pc = fe_cnt;
    mode = 0;
    for (int b = 0; b < 8; b++) begin
      if (b == 4) mode = 1;
      send(0, 100, -40, b == 7);
    end
    send(0, 100, -40, 0);
    drain();
    chk("short_frame_err", fe_cnt - pc == 1, fe_cnt - pc, 1);
    chk("short_peak_bin", lpk_bin[0] === 4'd0, lpk_bin[0], 0);
    chk("short_peak_mag", lpk_mag[0] === 16'd120, lpk_mag[0], 120);
    for (int b = 1; b < 10; b++) send(0, 100, -40, 0);
    pc = pk_cnt;
    rst = 1;
    #1;
    chk("midrst_out_valid", out_valid === 1'b0, out_valid, 0);
    chk("midrst_out_mag", out_mag === 16'd0, out_mag, 0);
    chk("midrst_peak_valid", peak_valid === 1'b0, peak_valid, 0);
    oq.delete();
    pq.delete();
    for (int c = 0; c < NC; c++) begin
      mbin[c] = 0; mlat[c] = 0; pkb[c] = 0; pkm[c] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    mode = 0;
    frame(0, 6, 300, 300);
    drain();
    chk("post_rst_reports", pk_cnt - pc == 1, pk_cnt - pc, 1);
    chk("post_rst_peak_bin", lpk_bin[0] === 4'd6, lpk_bin[0], 6);
    chk("post_rst_peak_mag", lpk_mag[0] === 16'd450, lpk_mag[0], 450);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
